q_preimage_scanner: RTL
=======================

// Module: q_preimage_scanner
// PURPOSE
//  Inverse companion to the combinational Q evaluator (Q: IN_W-bit x -> OUT_W-bit Qx).
//  Accepts a target value y and sweeps x = 0 .. 2^IN_W-1 through an external Q
//  instance, streaming out every x with Q(x) == y, then reports the match count.
//  Sits between a request source (controller/bench) and a match consumer.
// PARAMETERS
//  IN_W   4  width of Q input x; sweep length 2^IN_W
//  OUT_W  2  width of Q output Qx and of target y
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        async active-low reset
//  req_valid  in   1        request strobe; target on req_y
//  req_y      in   OUT_W    target Q value
//  req_ready  out  1        high only in IDLE
//  abort      in   1        sync cancel of an active scan
//  x_o        out  IN_W     x driven to external Q instance
//  qx_i       in   OUT_W    Qx returned by external Q, same cycle (combinational)
//  m_valid    out  1        match available on m_x
//  m_x        out  IN_W     matching x
//  m_ready    in   1        consumer accepts match
//  busy       out  1        high in SCAN or EMIT
//  done       out  1        one-cycle pulse at end of scan
//  count      out  IN_W+1   matches in last scan; valid when done=1, held after
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt=0, target=0, x_o=0, m_valid=0,
//   m_x=0, busy=0, done=0, count=0, req_ready=1 once released.
//  States IDLE, SCAN, EMIT, DONE.
//  IDLE: req_ready=1. req_valid=1 at edge -> latch target=req_y, cnt=0,
//   matches=0, -> SCAN. No other input has effect.
//  SCAN: x_o=cnt. Per cycle compare qx_i with target:
//   match -> m_x<=cnt, m_valid<=1, matches+1, -> EMIT;
//   no match, cnt<2^IN_W-1 -> cnt+1, stay;
//   no match, cnt==2^IN_W-1 -> DONE.
//  EMIT: m_valid=1, m_x stable, x_o held at cnt until m_valid&m_ready at edge:
//   m_valid<=0; cnt<max -> cnt+1, SCAN; cnt==max -> DONE.
//   m_ready may be high on the first EMIT cycle (one-cycle handshake).
//  DONE: done=1 for exactly one cycle, count<=matches, -> IDLE.
//  Timing: no-match scan = 2^IN_W SCAN cycles + 1 DONE cycle; each match
//   adds >=1 EMIT cycle. req_valid to first x_o=0 evaluation: 1 cycle.
//  cnt is IN_W+1 bits internally or saturates; never wraps to 0 within a scan.
//  matches/count width IN_W+1 so all 2^IN_W matches (16 for IN_W=4) fit.
//  abort=1 in SCAN/EMIT: next edge -> IDLE, m_valid=0, no done pulse, count
//   unchanged. abort beats match and handshake in the same cycle. Ignored in
//   IDLE/DONE.
//  req_valid while busy or in DONE: ignored (req_ready=0), not queued.
//  Reset mid-scan: outputs to reset values immediately; pending match dropped.
//  qx_i sampled only in SCAN; x values skipped during EMIT are never lost
//   because cnt does not advance until the match handshake completes.
// TESTING
//  Bench Q model: Qx = x[1:0] (IN_W=4, OUT_W=2).
//  T1 target 2, m_ready=1 -> m_x 2,6,10,14 in order, done pulse, count=4.
//  T2 target 3, m_ready low 5 cycles per match -> m_x held stable, same 3,7,
//   11,15, count=4, no match duplicated or skipped.
//  T3 Q model forced to 0, target 1 -> no m_valid, done after 16 SCAN cycles,
//   count=0; target 0 -> all x 0..15 emitted, count=16.
//  T4 abort asserted on 2nd match (x=6) with m_ready=1 -> IDLE, no done,
//   count keeps previous value, req_ready=1 next cycle.
//  T5 rst_n pulsed low mid-EMIT -> m_valid/busy fall without clock edge;
//   fresh request afterwards completes normally.
//  T6 req_valid held high through entire scan -> exactly one scan, a second
//   scan starts only from the IDLE cycle after done.

Source files
------------

// File: rtl/q_preimage_scanner_if.sv
// ============================================================================
// Module   : q_preimage_scanner_if
// Brief    : Request, Q-evaluator and match-stream signals of the Q preimage scanner.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface q_preimage_scanner_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 2
);
   logic             req_valid;
   logic [OUT_W-1:0] req_y;
   logic             req_ready;
   logic             abort;
   logic [IN_W-1:0]  x_o;
   logic [OUT_W-1:0] qx_i;
   logic             m_valid;
   logic [IN_W-1:0]  m_x;
   logic             m_ready;
   logic             busy;
   logic             done;
   logic [IN_W:0]    count;

   modport master (
      output req_valid, req_y, abort, qx_i, m_ready,
      input  req_ready, x_o, m_valid, m_x, busy, done, count
   );

   modport slave (
      input  req_valid, req_y, abort, qx_i, m_ready,
      output req_ready, x_o, m_valid, m_x, busy, done, count
   );
endinterface

`default_nettype wire

// File: rtl/q_preimage_scanner.sv
// ============================================================================
// Module   : q_preimage_scanner
// Brief    : Sweeps x through an external Q evaluator and streams every x with Q(x)==y.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module q_preimage_scanner #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 2
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   q_preimage_scanner_if.slave s_bus
);
   localparam logic [1:0]      c_ST_IDLE = 2'd0;
   localparam logic [1:0]      c_ST_SCAN = 2'd1;
   localparam logic [1:0]      c_ST_EMIT = 2'd2;
   localparam logic [1:0]      c_ST_DONE = 2'd3;
   localparam logic [IN_W-1:0] c_X_MAX   = '1;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [IN_W-1:0]  r_cnt;
   logic [IN_W-1:0]  r_m_x;
   logic [OUT_W-1:0] r_target;
   logic [IN_W:0]    r_matches;
   logic [IN_W:0]    r_count;
   logic             w_match;
   logic             w_last;
   logic             w_req_ready;
   logic             w_busy;
   logic             w_done;
   logic             w_m_valid;

   assign w_match = (s_bus.qx_i == r_target);
   assign w_last  = (r_cnt == c_X_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (s_bus.req_valid) w_state_nxt = c_ST_SCAN;
         end
         c_ST_SCAN: begin
            if (s_bus.abort)  w_state_nxt = c_ST_IDLE;
            else if (w_match) w_state_nxt = c_ST_EMIT;
            else if (w_last)  w_state_nxt = c_ST_DONE;
         end
         c_ST_EMIT: begin
            // Abort wins over a handshake landing on the same edge
            if (s_bus.abort)        w_state_nxt = c_ST_IDLE;
            else if (s_bus.m_ready) w_state_nxt = w_last ? c_ST_DONE : c_ST_SCAN;
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_req_ready = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_m_valid   = 1'b0;
      case (r_state)
         c_ST_IDLE: w_req_ready = rst_n;
         c_ST_SCAN: w_busy      = 1'b1;
         c_ST_EMIT: begin
            w_busy    = 1'b1;
            w_m_valid = 1'b1;
         end
         default:   w_done      = 1'b1;
      endcase
   end

   // cnt only advances on a non-matching SCAN or a completed handshake, never past max
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_m_x     <= '0;
         r_target  <= '0;
         r_matches <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (s_bus.req_valid) begin
                  r_target  <= s_bus.req_y;
                  r_cnt     <= '0;
                  r_matches <= '0;
               end
            end
            c_ST_SCAN: begin
               if (!s_bus.abort) begin
                  if (w_match) begin
                     r_m_x     <= r_cnt;
                     r_matches <= r_matches + 1'b1;
                  end else if (!w_last) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            c_ST_EMIT: begin
               if (!s_bus.abort && s_bus.m_ready && !w_last) r_cnt <= r_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Loaded on entry to DONE so count is already valid while done is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_state_nxt == c_ST_DONE) begin
         r_count <= r_matches;
      end
   end

   assign s_bus.req_ready = w_req_ready;
   assign s_bus.busy      = w_busy;
   assign s_bus.done      = w_done;
   assign s_bus.m_valid   = w_m_valid;
   assign s_bus.m_x       = r_m_x;
   assign s_bus.x_o       = r_cnt;
   assign s_bus.count     = r_count;

endmodule

`default_nettype wire
